mlp_mul_share_arb: RTL
======================

Name: mlp_mul_share_arb

Overview:
- Shares one pipelined unsigned multiplier (9b x 11b -> 20b, 2-cycle latency, ce-gated, no reset) among NUM_REQ requesters in the MLP datapath.
- Round-robin arbitration issues at most one operand pair per cycle.
- Tracks requester IDs through the multiplier pipeline and returns each product on a single valid/ready result port.
- Back-pressure on the result port stalls the multiplier via its ce.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- A_W, 9: din0 operand width.
- B_W, 11: din1 operand width.
- P_W, 20: product width; must equal A_W+B_W.
- MUL_LAT, 2: multiplier latency in ce-enabled cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept.
- req_a  in  NUM_REQ*A_W  packed operand A; requester i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed operand B; same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  P_W  product.
- res_id  out  ID_W  index of the originating requester; ID_W = max(1, clog2(NUM_REQ)).
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  A_W  to multiplier din0.
- mul_din1  out  B_W  to multiplier din1.
- mul_dout  in  P_W  from multiplier dout.

Behaviour:
- Reset (async, active-high):
  - tag pipeline valids = 0; rr pointer = 0.
  - res_valid = 0; req_ready = 0; mul_ce = 1.
  - Multiplier contents are don't-care because tags are cleared.
- Stall:
  - stall = res_valid & !res_ready; mul_ce = !stall.
  - While stalled: no grants, tag pipeline frozen, res_data and res_id held stable.
- Arbitration (combinational):
  - Among asserted req_valid, grant the first index at or after rr pointer, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 only when mul_ce = 1 and req_valid[g] = 1.
  - req_ready is one-hot or zero.
  - Handshake = req_valid[i] & req_ready[i].
  - Requesters must hold valid and operands until accepted.
- Issue:
  - mul_din0/mul_din1 = operands of the granted requester.
  - When there is no grant, drive 0.
- Pointer: on a handshake with requester g, rr pointer <= (g+1) mod NUM_REQ; otherwise unchanged.
- Tag pipeline:
  - MUL_LAT stages of {valid, id}, shifted only when mul_ce = 1.
  - Stage 0 loads {handshake, g}; a bubble enters when there is no grant.
- Result:
  - res_valid = last-stage valid; res_id = last-stage id; res_data = mul_dout.
  - Latency, handshake to res_valid: exactly MUL_LAT cycles when unstalled.
  - Throughput: 1 result/cycle.
- Ordering: results leave in issue order; no reordering.
- Simultaneous events:
  - A result accepted and a new request in the same cycle are both legal, giving full-rate streaming.
  - A single requester may be granted on consecutive cycles if it is the only one valid.
- Reset mid-operation: in-flight products are discarded and no res_valid follows.
- Arithmetic: the product is computed solely by the external multiplier; no truncation here.

Optional Feature:
- Macro MLP_MUL_ARB_PRIO_EN.
- Defined: requester 0 has strict priority whenever req_valid[0] = 1. The remaining requesters arbitrate round-robin among themselves, and a grant to requester 0 does not move the pointer.
- Undefined: pure round-robin over all NUM_REQ as above.

Decomposition:
- Package mlp_mul_arb_pkg:
  - default width constants (A_W, B_W, P_W, MUL_LAT, NUM_REQ);
  - ID_W derivation function;
  - tag struct typedef {logic vld; logic [ID_W-1:0] id}.
- Sub-module mlp_mul_rr_pick:
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant, encoded index, any-grant;
  - purely combinational, reused elsewhere for arbitration.
- Tag pipeline and stall logic stay in the top.

Test Plan:
- Single requester: req 2 with a=300, b=1500, res_ready=1 -> after 2 cycles res_valid=1, res_data=450000, res_id=2.
- All 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; res_id follows the same sequence, 2 cycles later.
- Back-pressure: pipeline holding 2 results, res_ready=0 for 5 cycles -> mul_ce=0, req_ready all 0, res_data/res_id stable; on release, both results drain in order.
- Operand extremes: a=511, b=2047 -> res_data=1046017. a=0, b=2047 -> 0.
- Reset asserted with 2 results in flight -> res_valid=0 immediately and stays 0 after release; the next grant goes to requester 0.
- MLP_MUL_ARB_PRIO_EN defined, req 0 and 1 valid continuously -> requester 0 granted every cycle; requester 1 is granted only after req 0 deasserts.

Source files
------------

// File: rtl/mlp_mul_arb_pkg.sv
// mlp_mul_arb_pkg: default widths, ID width helper and pipeline tag type for the shared multiplier arbiter
package mlp_mul_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 9;
  localparam int DEF_B_W     = 11;
  localparam int DEF_P_W     = 20;
  localparam int DEF_MUL_LAT = 2;
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int DEF_ID_W = id_w(DEF_NUM_REQ);
  typedef struct packed {
    logic                vld;
    logic [DEF_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mlp_mul_rr_pick.sv
// mlp_mul_rr_pick: combinational round-robin picker, first request at or after the pointer wins
module mlp_mul_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  // scan N positions starting at the pointer, wrapping modulo N
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_en && !o_any && i_req[IW'((int'(i_ptr) + k) % N)]) begin
        o_any = 1'b1;
        o_gnt[IW'((int'(i_ptr) + k) % N)] = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mlp_mul_share_arb.sv
// mlp_mul_share_arb: shares one pipelined multiplier among requesters; MLP_MUL_ARB_PRIO_EN gives requester 0 strict priority
module mlp_mul_share_arb
  import mlp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W,
  parameter int MUL_LAT = DEF_MUL_LAT,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [P_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout
);
  logic               w_ce, w_en, w_p0, w_rr_any, w_any;
  logic [NUM_REQ-1:0] w_rr_req, w_rr_gnt;
  logic [ID_W-1:0]    w_idx, w_ptr_nxt, r_ptr;
  logic               r_vld [MUL_LAT];
  logic [ID_W-1:0]    r_id  [MUL_LAT];

  assign w_ce = ~(res_valid & ~res_ready);
  assign w_en = w_ce & ~reset;
`ifdef MLP_MUL_ARB_PRIO_EN
  assign w_p0     = w_en & req_valid[0];
  assign w_rr_req = req_valid & ~NUM_REQ'(1);
`else
  assign w_p0     = 1'b0;
  assign w_rr_req = req_valid;
`endif

  mlp_mul_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .i_req(w_rr_req),
    .i_ptr(r_ptr),
    .i_en (w_en & ~w_p0),
    .o_gnt(w_rr_gnt),
    .o_idx(w_idx),
    .o_any(w_rr_any)
  );

  assign w_any     = w_rr_any | w_p0;
  assign req_ready = w_rr_gnt | {{(NUM_REQ-1){1'b0}}, w_p0};
  assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
  assign mul_ce    = w_ce;
  assign res_valid = r_vld[MUL_LAT-1];
  assign res_id    = r_id[MUL_LAT-1];
  assign res_data  = mul_dout;

  // steer the granted requester's operands onto the multiplier, zero when idle
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mul_din0 = mul_din0 | ({A_W{req_ready[i]}} & req_a[i*A_W +: A_W]);
      mul_din1 = mul_din1 | ({B_W{req_ready[i]}} & req_b[i*B_W +: B_W]);
    end
  end

  // pointer advances past round-robin winners; tag valids shift with the multiplier
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      for (int s = 0; s < MUL_LAT; s++) r_vld[s] <= 1'b0;
    end else if (w_ce) begin
      if (w_rr_any) r_ptr <= w_ptr_nxt;
      r_vld[0] <= w_any;
      for (int s = 1; s < MUL_LAT; s++) r_vld[s] <= r_vld[s-1];
    end
  end

  // requester ids ride alongside the valids; meaningless under a cleared valid so no reset
  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_id[0] <= w_idx;
      for (int s = 1; s < MUL_LAT; s++) r_id[s] <= r_id[s-1];
    end
  end
endmodule
